// File: rtl/int_ctrl_if.sv
// int_ctrl_if
//   Bundles the signals between the trap/interrupt arbiter and its
//   neighbours: the commit stage, the CSR file and the fetch/PC logic.
//
//   Commit/interrupt side (into int_ctrl):
//     ext_irq_i, timer_irq_i, soft_irq_i   level interrupt lines
//     inst_valid_i, inst_addr_i            retiring instruction and its PC
//     excepttype_i                         pipeline exception code
//   CSR side (into int_ctrl):
//     mstatus_i, mie_i, mtvec_i, mepc_i
//   Command side (out of int_ctrl):
//     excepttype_o, current_inst_addr_o    trap command to the CSR file
//     flush_o, new_pc_o                    pipeline flush and redirect
//     pending_o                            registered pending view
//
//   Modports:
//     master - the surrounding pipeline/CSR logic (drives the inputs)
//     slave  - int_ctrl itself
interface int_ctrl_if;
  logic        ext_irq_i;
  logic        timer_irq_i;
  logic        soft_irq_i;
  logic        inst_valid_i;
  logic [31:0] inst_addr_i;
  logic [31:0] excepttype_i;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] pending_o;

  modport master (
    output ext_irq_i, timer_irq_i, soft_irq_i,
    output inst_valid_i, inst_addr_i, excepttype_i,
    output mstatus_i, mie_i, mtvec_i, mepc_i,
    input  excepttype_o, current_inst_addr_o, flush_o, new_pc_o, pending_o
  );

  modport slave (
    input  ext_irq_i, timer_irq_i, soft_irq_i,
    input  inst_valid_i, inst_addr_i, excepttype_i,
    input  mstatus_i, mie_i, mtvec_i, mepc_i,
    output excepttype_o, current_inst_addr_o, flush_o, new_pc_o, pending_o
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl
//   Trap/interrupt arbiter. At each instruction boundary it picks the
//   highest-priority event (synchronous exception, then external, timer,
//   software interrupt), registers the code and PC, and issues a one-cycle
//   trap or mret command together with a pipeline flush and redirect PC.
//   A HOLD cycle follows every trap so the CSR file can clear MIE before
//   the next boundary is considered.
//
//   Ports:
//     clk  - system clock, all logic on posedge
//     rst  - asynchronous, active-low reset
//     bus  - int_ctrl_if.slave (interrupt lines, commit info, CSR values,
//            trap command, flush/redirect, pending view)
//
//   Parameters:
//     SYNC_STAGES - flops in the ext_irq_i synchronizer (2..3)
module int_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  int_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] CODE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CODE_ECALL   = 32'h0000_0008;
  localparam logic [31:0] CODE_MRET    = 32'h0000_000A;
  localparam logic [31:0] CODE_EXT     = 32'h8000_000B;
  localparam logic [31:0] CODE_TIMER   = 32'h8000_0007;
  localparam logic [31:0] CODE_SOFT    = 32'h8000_0000;

  state_t                 state_q;
  state_t                 next_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_sync;
  logic [31:0]            pending_q;
  logic [31:0]            code_q;
  logic [31:0]            addr_q;
  logic                   take;
  logic [31:0]            sel_code;
  logic [31:0]            sync_code;
  logic                   ext_en;
  logic                   timer_en;
  logic                   soft_en;
  logic [31:0]            trap_base;
  logic                   unused_bits;

  // Only a few CSR bits matter here; the rest are deliberately ignored.
  assign unused_bits = ^{bus.mstatus_i[31:4], bus.mstatus_i[2:0],
                         bus.mie_i[31:12], bus.mie_i[10:8],
                         bus.mie_i[6:4], bus.mie_i[2:0]};

  // ext_irq_i is asynchronous to clk, so it goes through a flop chain
  // before anything looks at it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ext_irq_i};
    end
  end

  assign ext_sync = sync_q[SYNC_STAGES-1];

  // Pending view is a registered copy of the (synchronized) lines,
  // independent of any masking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q       <= '0;
      pending_q[11]   <= ext_sync;
      pending_q[7]    <= bus.timer_irq_i;
      pending_q[3]    <= bus.soft_irq_i;
    end
  end

  assign bus.pending_o = pending_q;

  // Masking: an interrupt counts only when global MIE and its own enable
  // are both set. Timer and soft lines are already synchronous.
  assign ext_en   = bus.mstatus_i[3] & bus.mie_i[11] & ext_sync;
  assign timer_en = bus.mstatus_i[3] & bus.mie_i[7]  & bus.timer_irq_i;
  assign soft_en  = bus.mstatus_i[3] & bus.mie_i[3]  & bus.soft_irq_i;

  // Unknown non-zero pipeline codes are folded into illegal instruction.
  always_comb begin
    sync_code = CODE_ILLEGAL;
    if (bus.excepttype_i == CODE_ECALL || bus.excepttype_i == CODE_MRET ||
        bus.excepttype_i == CODE_ILLEGAL) begin
      sync_code = bus.excepttype_i;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state logic and event selection. Only IDLE samples the boundary;
  // TRAP and HOLD always last exactly one cycle each.
  always_comb begin
    next_state = state_q;
    take       = 1'b0;
    sel_code   = '0;
    case (state_q)
      IDLE: begin
        if (bus.inst_valid_i) begin
          if (bus.excepttype_i != 32'd0) begin
            take     = 1'b1;
            sel_code = sync_code;
          end else if (ext_en) begin
            take     = 1'b1;
            sel_code = CODE_EXT;
          end else if (timer_en) begin
            take     = 1'b1;
            sel_code = CODE_TIMER;
          end else if (soft_en) begin
            take     = 1'b1;
            sel_code = CODE_SOFT;
          end
        end
        if (take) begin
          next_state = TRAP;
        end
      end
      TRAP:    next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Code and PC of the chosen event are captured on the IDLE->TRAP edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= '0;
      addr_q <= '0;
    end else if (take) begin
      code_q <= sel_code;
      addr_q <= bus.inst_addr_i;
    end
  end

  assign trap_base = {bus.mtvec_i[31:2], 2'b00};

  // Outputs are decoded from the state so that an asynchronous reset
  // clears them immediately. Vectored mode only offsets interrupts; the
  // add wraps naturally at 32 bits.
  always_comb begin
    bus.excepttype_o        = '0;
    bus.current_inst_addr_o = '0;
    bus.flush_o             = 1'b0;
    bus.new_pc_o            = '0;
    if (state_q == TRAP) begin
      bus.excepttype_o        = code_q;
      bus.current_inst_addr_o = addr_q;
      bus.flush_o             = 1'b1;
      if (code_q == CODE_MRET) begin
        bus.new_pc_o = bus.mepc_i;
      end else if (code_q[31] && bus.mtvec_i[1:0] == 2'b01) begin
        bus.new_pc_o = trap_base + {26'd0, code_q[3:0], 2'b00};
      end else begin
        bus.new_pc_o = trap_base;
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl
//   Directed bench for int_ctrl: one task per scenario, each with its own
//   hand-computed expectations. Inputs change 1 time unit after the rising
//   edge and outputs are sampled at that same point.
module tb_int_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int_ctrl_if bus ();

  int_ctrl #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ext_irq_i    = 1'b0;
    bus.timer_irq_i  = 1'b0;
    bus.soft_irq_i   = 1'b0;
    bus.inst_valid_i = 1'b0;
    bus.inst_addr_i  = '0;
    bus.excepttype_i = '0;
    bus.mstatus_i    = '0;
    bus.mie_i        = '0;
    bus.mtvec_i      = '0;
    bus.mepc_i       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (bus.excepttype_o !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_code: got %h expected %h", bus.excepttype_o, 32'h0);
    end
    checks++;
    if (bus.flush_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flush: got %b expected 0", bus.flush_o);
    end
    checks++;
    if (bus.new_pc_o !== 32'h0 || bus.current_inst_addr_o !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_pc: got new_pc %h addr %h expected 0", bus.new_pc_o, bus.current_inst_addr_o);
    end
    checks++;
    if (bus.pending_o !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_pending: got %h expected 0", bus.pending_o);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ecall();
    bus.mtvec_i      = 32'h200;
    bus.mstatus_i    = 32'h0;
    bus.inst_valid_i = 1'b1;
    bus.excepttype_i = 32'h8;
    bus.inst_addr_i  = 32'h100;
    tick();
    checks++;
    if (bus.excepttype_o !== 32'h8 || bus.flush_o !== 1'b1) begin
      errors++; $display("[TB] FAIL ecall_code: got %h flush %b expected 8 flush 1", bus.excepttype_o, bus.flush_o);
    end
    checks++;
    if (bus.current_inst_addr_o !== 32'h100 || bus.new_pc_o !== 32'h200) begin
      errors++; $display("[TB] FAIL ecall_pc: got addr %h new_pc %h expected 100/200", bus.current_inst_addr_o, bus.new_pc_o);
    end
    bus.inst_valid_i = 1'b0;
    bus.excepttype_i = 32'h0;
    tick();
    checks++;
    if (bus.excepttype_o !== 32'h0 || bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0 ||
        bus.current_inst_addr_o !== 32'h0) begin
      errors++; $display("[TB] FAIL ecall_hold: got code %h flush %b expected all 0", bus.excepttype_o, bus.flush_o);
    end
    tick();
  endtask

  task automatic test_no_valid();
    bus.inst_valid_i = 1'b0;
    bus.excepttype_i = 32'h8;
    bus.inst_addr_i  = 32'h140;
    tick();
    checks++;
    if (bus.flush_o !== 1'b0 || bus.excepttype_o !== 32'h0) begin
      errors++; $display("[TB] FAIL no_valid: got code %h flush %b expected 0", bus.excepttype_o, bus.flush_o);
    end
    bus.excepttype_i = 32'h0;
    tick();
  endtask

  task automatic test_illegal_map();
    bus.mtvec_i      = 32'h300;
    bus.inst_valid_i = 1'b1;
    bus.excepttype_i = 32'h5;
    bus.inst_addr_i  = 32'h180;
    tick();
    checks++;
    if (bus.excepttype_o !== 32'h2 || bus.new_pc_o !== 32'h300) begin
      errors++; $display("[TB] FAIL illegal_map: got %h pc %h expected 2/300", bus.excepttype_o, bus.new_pc_o);
    end
    bus.inst_valid_i = 1'b0;
    bus.excepttype_i = 32'h0;
    tick();
    tick();
  endtask

  task automatic test_ext_vectored();
    bool_seen_second_reset();
  endtask

  // Body of the external-interrupt vectored scenario, including the
  // check that no second trap fires while MIE stays cleared.
  task automatic bool_seen_second_reset();
    logic second;
    bus.mstatus_i    = 32'h8;
    bus.mie_i        = 32'h800;
    bus.mtvec_i      = 32'h201;
    bus.inst_valid_i = 1'b1;
    bus.inst_addr_i  = 32'h300;
    bus.ext_irq_i    = 1'b1;
    tick();
    checks++;
    if (bus.flush_o !== 1'b0) begin
      errors++; $display("[TB] FAIL ext_early1: got flush %b expected 0", bus.flush_o);
    end
    tick();
    checks++;
    if (bus.flush_o !== 1'b0) begin
      errors++; $display("[TB] FAIL ext_early2: got flush %b expected 0", bus.flush_o);
    end
    tick();
    checks++;
    if (bus.excepttype_o !== 32'h8000000B || bus.new_pc_o !== 32'h22C) begin
      errors++; $display("[TB] FAIL ext_trap: got %h pc %h expected 8000000b/22c", bus.excepttype_o, bus.new_pc_o);
    end
    checks++;
    if (bus.current_inst_addr_o !== 32'h300 || bus.pending_o[11] !== 1'b1) begin
      errors++; $display("[TB] FAIL ext_addr: got addr %h pend11 %b expected 300/1", bus.current_inst_addr_o, bus.pending_o[11]);
    end
    bus.mstatus_i = 32'h0;
    second = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.flush_o !== 1'b0) second = 1'b1;
    end
    checks++;
    if (second !== 1'b0) begin
      errors++; $display("[TB] FAIL ext_retrigger: got second trap %b expected 0", second);
    end
    bus.ext_irq_i    = 1'b0;
    bus.mie_i        = 32'h0;
    bus.inst_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_masking();
    logic fired;
    fired = 1'b0;
    bus.timer_irq_i  = 1'b1;
    bus.inst_valid_i = 1'b1;
    bus.inst_addr_i  = 32'h3C0;
    bus.mstatus_i    = 32'h8;
    bus.mie_i        = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.excepttype_o !== 32'h0) fired = 1'b1;
    end
    bus.mstatus_i = 32'h0;
    bus.mie_i     = 32'h80;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.excepttype_o !== 32'h0) fired = 1'b1;
    end
    checks++;
    if (fired !== 1'b0) begin
      errors++; $display("[TB] FAIL mask_no_trap: got fired %b expected 0", fired);
    end
    checks++;
    if (bus.pending_o !== 32'h80) begin
      errors++; $display("[TB] FAIL mask_pending: got %h expected 00000080", bus.pending_o);
    end
    bus.timer_irq_i  = 1'b0;
    bus.mie_i        = 32'h0;
    bus.inst_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_timer_wrap();
    bus.mstatus_i    = 32'h8;
    bus.mie_i        = 32'h80;
    bus.mtvec_i      = 32'hFFFF_FFF1;
    bus.timer_irq_i  = 1'b1;
    bus.inst_valid_i = 1'b1;
    bus.inst_addr_i  = 32'h600;
    tick();
    checks++;
    if (bus.excepttype_o !== 32'h80000007 || bus.new_pc_o !== 32'h0000000C) begin
      errors++; $display("[TB] FAIL timer_wrap: got %h pc %h expected 80000007/0000000c", bus.excepttype_o, bus.new_pc_o);
    end
    bus.mstatus_i    = 32'h0;
    bus.timer_irq_i  = 1'b0;
    bus.inst_valid_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    bus.mstatus_i    = 32'h8;
    bus.mie_i        = 32'h8;
    bus.mtvec_i      = 32'h200;
    bus.soft_irq_i   = 1'b1;
    bus.inst_valid_i = 1'b1;
    bus.excepttype_i = 32'h2;
    bus.inst_addr_i  = 32'h400;
    tick();
    checks++;
    if (bus.excepttype_o !== 32'h2 || bus.current_inst_addr_o !== 32'h400 || bus.new_pc_o !== 32'h200) begin
      errors++; $display("[TB] FAIL simul_sync: got %h addr %h pc %h expected 2/400/200", bus.excepttype_o, bus.current_inst_addr_o, bus.new_pc_o);
    end
    bus.mstatus_i    = 32'h0;
    bus.excepttype_i = 32'h0;
    bus.inst_addr_i  = 32'h404;
    tick();
    checks++;
    if (bus.flush_o !== 1'b0) begin
      errors++; $display("[TB] FAIL simul_hold: got flush %b expected 0", bus.flush_o);
    end
    bus.mstatus_i = 32'h8;
    tick();
    checks++;
    if (bus.flush_o !== 1'b0) begin
      errors++; $display("[TB] FAIL simul_idle: got flush %b expected 0", bus.flush_o);
    end
    tick();
    checks++;
    if (bus.excepttype_o !== 32'h80000000 || bus.current_inst_addr_o !== 32'h404 || bus.new_pc_o !== 32'h200) begin
      errors++; $display("[TB] FAIL simul_soft: got %h addr %h pc %h expected 80000000/404/200", bus.excepttype_o, bus.current_inst_addr_o, bus.new_pc_o);
    end
    bus.mstatus_i    = 32'h0;
    bus.soft_irq_i   = 1'b0;
    bus.mie_i        = 32'h0;
    bus.inst_valid_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_mret();
    bus.mtvec_i      = 32'h201;
    bus.mepc_i       = 32'h1234;
    bus.inst_valid_i = 1'b1;
    bus.excepttype_i = 32'hA;
    bus.inst_addr_i  = 32'h500;
    tick();
    checks++;
    if (bus.excepttype_o !== 32'hA || bus.new_pc_o !== 32'h1234 || bus.flush_o !== 1'b1) begin
      errors++; $display("[TB] FAIL mret: got %h pc %h flush %b expected a/1234/1", bus.excepttype_o, bus.new_pc_o, bus.flush_o);
    end
    bus.inst_valid_i = 1'b0;
    bus.excepttype_i = 32'h0;
    tick();
    checks++;
    if (bus.excepttype_o !== 32'h0 || bus.new_pc_o !== 32'h0) begin
      errors++; $display("[TB] FAIL mret_after: got %h pc %h expected 0", bus.excepttype_o, bus.new_pc_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.mtvec_i      = 32'h200;
    bus.inst_valid_i = 1'b1;
    bus.excepttype_i = 32'h8;
    bus.inst_addr_i  = 32'h700;
    tick();
    checks++;
    if (bus.flush_o !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_trap: got flush %b expected 1", bus.flush_o);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.flush_o !== 1'b0 || bus.excepttype_o !== 32'h0) begin
      errors++; $display("[TB] FAIL rstmid_async: got flush %b code %h expected 0", bus.flush_o, bus.excepttype_o);
    end
    bus.inst_valid_i = 1'b0;
    bus.excepttype_i = 32'h0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.flush_o !== 1'b0 || bus.excepttype_o !== 32'h0) begin
      errors++; $display("[TB] FAIL rstmid_after: got flush %b code %h expected 0", bus.flush_o, bus.excepttype_o);
    end
    bus.inst_valid_i = 1'b1;
    bus.excepttype_i = 32'h8;
    bus.inst_addr_i  = 32'h704;
    tick();
    checks++;
    if (bus.excepttype_o !== 32'h8 || bus.current_inst_addr_o !== 32'h704) begin
      errors++; $display("[TB] FAIL rstmid_new: got %h addr %h expected 8/704", bus.excepttype_o, bus.current_inst_addr_o);
    end
    bus.inst_valid_i = 1'b0;
    bus.excepttype_i = 32'h0;
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] starting int_ctrl bench");
    test_reset();
    test_ecall();
    test_no_valid();
    test_illegal_map();
    test_ext_vectored();
    test_masking();
    test_timer_wrap();
    test_back_to_back();
    test_mret();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case the stimulus ever stops advancing.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Trap/interrupt arbiter that generates the `excepttype`/`current_inst_addr` stimulus consumed by the CSR file.
- Samples synchronous exceptions from the pipeline at the instruction boundary, plus external, timer and software interrupt lines. Masks interrupts with the CSR's mstatus/mie, then issues a one-cycle trap or mret command with a pipeline flush and redirect PC.
- Sits between the commit stage, the CSR file and the PC/fetch logic.

Parameters:
- SYNC_STAGES, 2, number of flops in the ext_irq_i synchronizer (legal range 2..3).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset; clears all state on assertion.
- ext_irq_i  in  1  external interrupt, level, asynchronous to clk.
- timer_irq_i  in  1  timer interrupt, level, synchronous.
- soft_irq_i  in  1  software interrupt, level, synchronous.
- inst_valid_i  in  1  an instruction retires this cycle.
- inst_addr_i  in  32  PC of the retiring instruction.
- excepttype_i  in  32  pipeline exception code for the retiring instruction: 0 none, 0x2 illegal, 0x8 ecall, 0xA mret.
- mstatus_i  in  32  CSR mstatus; bit 3 = MIE.
- mie_i  in  32  CSR mie; bit 11 MEIE, bit 7 MTIE, bit 3 MSIE.
- mtvec_i  in  32  CSR mtvec; [1:0] mode (0 direct, 1 vectored).
- mepc_i  in  32  CSR mepc.
- excepttype_o  out  32  trap command to the CSR file; non-zero for exactly one cycle.
- current_inst_addr_o  out  32  PC associated with excepttype_o.
- flush_o  out  1  one-cycle pipeline flush.
- new_pc_o  out  32  redirect target; valid while flush_o is high.
- pending_o  out  32  pending view: bit 11 ext (synchronized), bit 7 timer, bit 3 soft.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; synchronizer flops 0.
- ext_irq_i passes through a SYNC_STAGES-flop synchronizer. Timer and soft lines are used directly. All interrupt lines are level-sensitive; there is no internal latch, so a line dropped before it is taken is lost.
- Enabled interrupt, per source: mstatus_i[3] & mie_i[bit] & pending.
- FSM states: IDLE, TRAP, HOLD.
- IDLE → TRAP when inst_valid_i=1 and either excepttype_i≠0 or any enabled interrupt exists. Selected code and address are registered on that edge. With inst_valid_i=0, nothing is taken.
- Priority, highest first:
  - synchronous exception (ecall, illegal, mret; these ignore MIE);
  - external → excepttype_o 0x8000000B;
  - timer → 0x80000007;
  - software → 0x80000000 (cause 0 per CSR decode).
- Synchronous codes pass through unchanged: 0x2, 0x8, 0xA. Any other non-zero excepttype_i is treated as 0x2 (illegal).
- When both a synchronous exception and an interrupt are present, the synchronous exception is taken. The interrupt remains pending and is evaluated again at the next boundary after HOLD.
- TRAP state, exactly one cycle:
  - excepttype_o = registered code; current_inst_addr_o = registered inst_addr_i; flush_o = 1.
  - new_pc_o for mret = mepc_i.
  - new_pc_o for all other traps = {mtvec_i[31:2],2'b00}.
  - Vectored mode (mtvec_i[1:0]=1) with an interrupt: base + 4*cause[3:0].
  - Next state: HOLD.
- HOLD state, one cycle: all outputs 0. inst_valid_i is ignored, since that instruction is already flushed. This gives the CSR time to clear MIE so the same level cannot retrigger. Next state: IDLE.
- Throughput: at most one trap per 3 cycles. Latency from boundary sample to excepttype_o is 1 cycle.
- Outside TRAP: excepttype_o, flush_o, new_pc_o and current_inst_addr_o are all 0.
- pending_o is registered: a one-cycle delay from the synchronized or raw line.
- Reset asserted mid-TRAP or mid-HOLD: outputs drop to 0 immediately (asynchronous reset). After release, the FSM restarts in IDLE.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Test Plan:
- Ecall at boundary:
  - Stimulus: inst_valid_i=1, excepttype_i=0x8, inst_addr_i=0x100, mtvec_i=0x200, MIE=0.
  - Next cycle: excepttype_o=0x8, current_inst_addr_o=0x100, flush_o=1, new_pc_o=0x200.
  - Cycle after: all outputs 0.
- External interrupt, vectored:
  - Stimulus: ext_irq_i held 1, MIE=1, mie_i=0x800, mtvec_i=0x201, inst_valid_i=1 continuously.
  - Response: after SYNC_STAGES+1 cycles, excepttype_o=0x8000000B and new_pc_o=0x22C.
  - No second trap while the CSR has MIE=0.
- Masking:
  - Stimulus: timer_irq_i=1 with mie_i[7]=0, or with MIE=0, for 20 cycles.
  - Response: excepttype_o stays 0; pending_o[7]=1.
- Simultaneous events:
  - Stimulus: excepttype_i=0x2 and soft_irq_i=1 (enabled) in the same cycle.
  - Response: 0x2 is issued first; 0x80000000 is issued 3 cycles later if MIE has been re-enabled.
- mret:
  - Stimulus: excepttype_i=0xA, mepc_i=0x1234.
  - Response: new_pc_o=0x1234, excepttype_o=0xA for one cycle.
- Reset mid-operation:
  - Stimulus: rst low during the TRAP cycle.
  - Response: flush_o and excepttype_o are 0 without waiting for a clock edge.
  - After release: no trap until a new boundary is sampled.
